countdown10to0: RTL and testbench
=================================

COUNTDOWN10TO0 -- requirements
Module: countdown10to0

Interface
REQ-001 SHALL have parameter START_VALUE, default 10, count loaded by load (legal 1..15; 0 illegal).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synced samples required to accept a btn level change (legal 1..255).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn  input  1  raw asynchronous push button, active-high.
REQ-006 SHALL have port load  input  1  synchronous, active-high; restarts the countdown.
REQ-007 SHALL have port counter_out  output  4  current count, unsigned binary.
REQ-008 SHALL have port tick  output  1  one-cycle pulse per accepted decrement.
REQ-009 SHALL have port done  output  1  high while in DONE state.
REQ-010 SHALL have port seg_tens  output  7  tens digit segments, active-high, bit0=a .. bit6=g.
REQ-011 SHALL have port seg_ones  output  7  ones digit segments, same encoding.

Function
REQ-012 SHALL pass btn through a 2-flop synchronizer before any other use.
REQ-013 SHALL hold a filtered button level that toggles only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch break restarts the stability count.
REQ-014 SHALL define a press as a 0->1 transition of the filtered level; at most one press per physical press.
REQ-015 SHALL implement FSM states IDLE, COUNT, DONE.
REQ-016 SHALL, in any state with load=1: counter_out<=START_VALUE, state<=COUNT, tick=0; load takes priority over a same-cycle press.
REQ-017 SHALL, in COUNT on press with load=0: counter_out<=counter_out-1 and tick=1 for exactly that cycle.
REQ-018 SHALL, when the decrement takes counter_out 1->0, enter DONE on the same edge; done=1 from the following cycle until load or reset.
REQ-019 SHALL ignore presses in IDLE and DONE (no tick, no count change); counter_out never wraps below 0.
REQ-020 SHALL update counter_out exactly DEBOUNCE_CYCLES+3 rising edges after the first edge at which btn is sampled high, given btn held stable high.
REQ-021 SHALL decode seg_ones/seg_tens combinationally from counter_out as decimal 0..15; digit codes 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F.
REQ-022 SHALL drive seg_tens=0x00 (blank) for counter_out<10 and 0x06 for counter_out>=10.
REQ-023 SHALL drive tick only from registered state (glitch-free), asserted only in the cycle counter_out decrements.

Reset
REQ-024 SHALL, while reset=1, immediately force state=IDLE, counter_out=0, tick=0, done=0, synchronizer flops=0, filtered level=0, stability count=0.
REQ-025 SHALL, for reset asserted mid-countdown, lose the count; after release the block stays IDLE until load.
REQ-026 SHALL, for btn held high across reset release, let the filtered level rise after debounce, but treat the resulting press as ignored (IDLE).
REQ-027 SHALL drive seg_ones=0x3F, seg_tens=0x00 during and after reset (count 0).

Verification
REQ-028 SHALL cover: reset, load pulse, 10 clean presses each held 20 cycles -> counter_out 10,9,..,0, 10 tick pulses, done=1 after the last, seg_tens 0x06 only at 10.
REQ-029 SHALL cover: btn bounce 1-0-1-0 at 1-cycle spacing then stable high (DEBOUNCE_CYCLES=4) -> exactly one decrement, at the edge REQ-020 predicts from the last bounce.
REQ-030 SHALL cover: in DONE, 3 further presses -> counter_out stays 0, no tick; then load -> counter_out=10, done=0 next cycle.
REQ-031 SHALL cover: load and press detected in the same cycle at count 5 -> counter_out=10, tick=0.
REQ-032 SHALL cover: reset asserted asynchronously between clock edges at count 7 -> counter_out=0, done=0 before the next clk edge; presses after release ignored until load.
REQ-033 SHALL cover: START_VALUE=15 -> seg_tens=0x06, seg_ones=0x6D after load; presses down to 0 with display tracking each value.

Source files
------------

// File: rtl/countdown10to0.sv
// -----------------------------------------------------------------------------
// countdown10to0
//   Push-button driven down counter with a two-digit 7-segment readout.
//   A raw button is synchronised, debounced and edge-detected. Each accepted
//   press decrements the count while the FSM is in COUNT. A load pulse
//   (re)starts the countdown from START_VALUE. Reaching zero parks the FSM in
//   DONE until the next load or reset.
//
// Parameters
//   START_VALUE      count loaded by load (1..15)
//   DEBOUNCE_CYCLES  consecutive stable synced samples needed to accept a
//                    button level change (1..255)
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   btn          raw asynchronous push button, active-high
//   load         synchronous, active-high; restarts the countdown
//   counter_out  current count, unsigned binary (registered)
//   tick         one-cycle pulse per accepted decrement (registered)
//   done         high while the FSM is in DONE (registered)
//   seg_tens     tens digit segments, active-high, bit0=a .. bit6=g (comb)
//   seg_ones     ones digit segments, same encoding (comb)
// -----------------------------------------------------------------------------
module countdown10to0 #(
  parameter int unsigned START_VALUE     = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       load,
  output logic [3:0] counter_out,
  output logic       tick,
  output logic       done,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DB_W  = 8;
  localparam int unsigned SEG_W = 7;

  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_VALUE);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TEN       = CNT_W'(10);

  // Elaboration-time parameter range guards
  if ((START_VALUE < 1) || (START_VALUE > 15)) begin : g_bad_start
    $error("countdown10to0: START_VALUE must be in 1..15");
  end
  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255)) begin : g_bad_db
    $error("countdown10to0: DEBOUNCE_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button front end
  // ---------------------------------------------------------------------------
  logic            sync_meta_q;
  logic            sync_q;
  logic            filt_q;
  logic            filt_prev_q;
  logic [DB_W-1:0] stable_cnt_q;
  logic            press_c;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= btn;
      sync_q      <= sync_meta_q;
    end
  end

  // Debounce: the filtered level follows the synced level only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q       <= 1'b0;
      stable_cnt_q <= '0;
    end else if (sync_q == filt_q) begin
      stable_cnt_q <= '0;
    end else if (stable_cnt_q == DB_LAST) begin
      filt_q       <= sync_q;
      stable_cnt_q <= '0;
    end else begin
      stable_cnt_q <= stable_cnt_q + DB_W'(1);
    end
  end

  // Rising-edge detector on the filtered level: one press per physical press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_prev_q <= 1'b0;
    end else begin
      filt_prev_q <= filt_q;
    end
  end

  assign press_c = filt_q & ~filt_prev_q;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_d;
  logic             tick_d;
  logic             done_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      counter_out <= '0;
      tick        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_out <= count_d;
      tick        <= tick_d;
      done        <= done_d;
    end
  end

  // Next state / next outputs; load wins over a same-cycle press
  always_comb begin
    state_d = state_q;
    count_d = counter_out;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (load) begin
      state_d = COUNT;
      count_d = START_CNT;
    end else begin
      case (state_q)
        COUNT: begin
          // Zero guard keeps the count from wrapping even if COUNT is
          // somehow entered with an empty counter.
          if (press_c && (counter_out != '0)) begin
            count_d = counter_out - CNT_W'(1);
            tick_d  = 1'b1;
            if (counter_out == CNT_W'(1)) begin
              state_d = DONE;
            end
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    // done tracks the state being entered so it is high for the whole stay
    done_d = (state_d == DONE);
  end

  // ---------------------------------------------------------------------------
  // Display decode (combinational from the registered count)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] ones_digit_c;

  always_comb begin
    ones_digit_c = counter_out;
    seg_tens     = '0;
    seg_ones     = '0;

    if (counter_out >= TEN) begin
      ones_digit_c = counter_out - TEN;
      seg_tens     = SEG_W'(7'h06);
    end

    case (ones_digit_c)
      4'd0:    seg_ones = SEG_W'(7'h3F);
      4'd1:    seg_ones = SEG_W'(7'h06);
      4'd2:    seg_ones = SEG_W'(7'h5B);
      4'd3:    seg_ones = SEG_W'(7'h4F);
      4'd4:    seg_ones = SEG_W'(7'h66);
      4'd5:    seg_ones = SEG_W'(7'h6D);
      4'd6:    seg_ones = SEG_W'(7'h7D);
      4'd7:    seg_ones = SEG_W'(7'h07);
      4'd8:    seg_ones = SEG_W'(7'h7F);
      4'd9:    seg_ones = SEG_W'(7'h6F);
      default: seg_ones = '0;
    endcase
  end

endmodule

// File: tb/tb_countdown10to0.sv
// -----------------------------------------------------------------------------
// tb_countdown10to0
//   Self-checking bench. Two instances share clk/reset: the default build
//   (START_VALUE=10) and a START_VALUE=15 build. sel routes btn/load to one
//   instance and picks which outputs are observed. Expected counts are pushed
//   to a queue when stimulus is applied and popped when the result is checked.
// -----------------------------------------------------------------------------
module tb_countdown10to0;

  localparam int unsigned DB  = 4;
  localparam int unsigned LAT = DB + 3;
  localparam int HOLD = 20;

  localparam int S_IDLE  = 0;
  localparam int S_COUNT = 1;
  localparam int S_DONE  = 2;

  logic clk = 1'b0;
  logic reset, btn, load, sel;

  logic       btn_a, load_a, btn_b, load_b;
  logic [3:0] cnt_a, cnt_b;
  logic       tick_a, tick_b, done_a, done_b;
  logic [6:0] tens_a, ones_a, tens_b, ones_b;

  logic [3:0] o_cnt;
  logic       o_tick, o_done;
  logic [6:0] o_tens, o_ones;

  always #5 clk = ~clk;

  assign btn_a  = sel ? 1'b0 : btn;
  assign load_a = sel ? 1'b0 : load;
  assign btn_b  = sel ? btn  : 1'b0;
  assign load_b = sel ? load : 1'b0;

  assign o_cnt  = sel ? cnt_b  : cnt_a;
  assign o_tick = sel ? tick_b : tick_a;
  assign o_done = sel ? done_b : done_a;
  assign o_tens = sel ? tens_b : tens_a;
  assign o_ones = sel ? ones_b : ones_a;

  countdown10to0 #(.START_VALUE(10), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .btn(btn_a), .load(load_a),
    .counter_out(cnt_a), .tick(tick_a), .done(done_a),
    .seg_tens(tens_a), .seg_ones(ones_a)
  );

  countdown10to0 #(.START_VALUE(15), .DEBOUNCE_CYCLES(DB)) dut15 (
    .clk(clk), .reset(reset), .btn(btn_b), .load(load_b),
    .counter_out(cnt_b), .tick(tick_b), .done(done_b),
    .seg_tens(tens_b), .seg_ones(ones_b)
  );

  int errors = 0;
  int checks = 0;
  int m_cnt, m_state, m_start;
  int tick_total;
  int exp_q[$];

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // One press: btn high for HOLD cycles then low for HOLD cycles, starting at
  // a falling edge. The decrement must land exactly LAT rising edges in.
  task automatic press_and_check(input string tag);
    int  seen_edge;
    int  extra;
    int  exp_edge;
    int  exp_cnt;
    logic [6:0] e_ones, e_tens;
    bit  dec;
    seen_edge = 0;
    extra     = 0;
    dec       = (m_state == S_COUNT) && (m_cnt > 0);
    exp_edge  = dec ? int'(LAT) : 0;
    exp_q.push_back(dec ? m_cnt - 1 : m_cnt);
    btn = 1'b1;
    for (int i = 1; i <= HOLD; i++) begin
      @(negedge clk);
      if (o_tick) begin
        if (seen_edge == 0) seen_edge = i;
        else extra++;
      end
    end
    btn = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      if (o_tick) extra++;
    end
    tick_total += extra + ((seen_edge != 0) ? 1 : 0);
    if (dec) begin
      m_cnt--;
      if (m_cnt == 0) m_state = S_DONE;
    end
    exp_cnt = exp_q.pop_front();
    e_ones  = digit_seg(exp_cnt % 10);
    e_tens  = (exp_cnt >= 10) ? 7'h06 : 7'h00;
    checks++;
    if (seen_edge !== exp_edge) begin
      errors++;
      $display("FAIL %s tick_edge: got %0d expected %0d", tag, seen_edge, exp_edge);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL %s extra_ticks: got %0d expected 0", tag, extra);
    end
    checks++;
    if (o_cnt !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", tag, o_cnt, exp_cnt);
    end
    checks++;
    if (o_done !== (m_state == S_DONE)) begin
      errors++;
      $display("FAIL %s done: got %0b expected %0b", tag, o_done, (m_state == S_DONE));
    end
    checks++;
    if (o_ones !== e_ones || o_tens !== e_tens) begin
      errors++;
      $display("FAIL %s segs: got %h/%h expected %h/%h", tag, o_tens, o_ones, e_tens, e_ones);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn   = 1'b0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_cnt !== 4'd0 || o_tick !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got cnt=%0d tick=%0b done=%0b expected 0/0/0", o_cnt, o_tick, o_done);
    end
    checks++;
    if (o_ones !== 7'h3F || o_tens !== 7'h00) begin
      errors++;
      $display("FAIL reset_segs: got %h/%h expected 00/3f", o_tens, o_ones);
    end
    reset   = 1'b0;
    m_cnt   = 0;
    m_state = S_IDLE;
    @(negedge clk);
    press_and_check("idle_press");
  endtask

  task automatic test_load();
    int exp_cnt;
    exp_q.push_back(m_start);
    load = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    m_cnt   = m_start;
    m_state = S_COUNT;
    exp_cnt = exp_q.pop_front();
    checks++;
    if (o_cnt !== 4'(exp_cnt) || o_tick !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL load: got cnt=%0d tick=%0b done=%0b expected %0d/0/0", o_cnt, o_tick, o_done, exp_cnt);
    end
    checks++;
    if (o_tens !== 7'h06 || o_ones !== digit_seg(exp_cnt % 10)) begin
      errors++;
      $display("FAIL load_segs: got %h/%h expected 06/%h", o_tens, o_ones, digit_seg(exp_cnt % 10));
    end
  endtask

  task automatic test_countdown();
    tick_total = 0;
    for (int i = 0; i < 10; i++) press_and_check("countdown");
    checks++;
    if (tick_total !== 10) begin
      errors++;
      $display("FAIL countdown_ticks: got %0d expected 10", tick_total);
    end
  endtask

  task automatic test_done_ignore();
    tick_total = 0;
    for (int i = 0; i < 3; i++) press_and_check("done_press");
    checks++;
    if (tick_total !== 0) begin
      errors++;
      $display("FAIL done_ticks: got %0d expected 0", tick_total);
    end
    test_load();
  endtask

  // Load asserted in exactly the cycle the filtered press is detected
  task automatic test_load_press();
    int exp_cnt;
    int stray;
    stray = 0;
    for (int i = 0; i < 5; i++) press_and_check("to_five");
    btn = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    exp_q.push_back(m_start);
    load = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    m_cnt   = m_start;
    m_state = S_COUNT;
    exp_cnt = exp_q.pop_front();
    checks++;
    if (o_cnt !== 4'(exp_cnt) || o_tick !== 1'b0) begin
      errors++;
      $display("FAIL load_press: got cnt=%0d tick=%0b expected %0d/0", o_cnt, o_tick, exp_cnt);
    end
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      if (o_tick) stray++;
    end
    btn = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      if (o_tick) stray++;
    end
    checks++;
    if (stray !== 0 || o_cnt !== 4'(m_cnt)) begin
      errors++;
      $display("FAIL load_press_after: got ticks=%0d cnt=%0d expected 0/%0d", stray, o_cnt, m_cnt);
    end
  endtask

  // 1-0-1-0 single-cycle bounce, then stable high: one decrement, timed
  // from the final rise
  task automatic test_bounce();
    int stray;
    stray = 0;
    btn = 1'b1; @(negedge clk); if (o_tick) stray++;
    btn = 1'b0; @(negedge clk); if (o_tick) stray++;
    btn = 1'b1; @(negedge clk); if (o_tick) stray++;
    btn = 1'b0; @(negedge clk); if (o_tick) stray++;
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL bounce_ticks: got %0d expected 0", stray);
    end
    press_and_check("bounce");
  endtask

  // Reset between clock edges mid-count; outputs clear before the next edge
  task automatic test_async_reset();
    while (m_cnt > 7) press_and_check("to_seven");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (o_cnt !== 4'd0 || o_done !== 1'b0 || o_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d done=%0b tick=%0b expected 0/0/0", o_cnt, o_done, o_tick);
    end
    checks++;
    if (o_ones !== 7'h3F || o_tens !== 7'h00) begin
      errors++;
      $display("FAIL async_reset_segs: got %h/%h expected 00/3f", o_tens, o_ones);
    end
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    m_cnt   = 0;
    m_state = S_IDLE;
    press_and_check("post_reset_press");
    press_and_check("post_reset_press2");
  endtask

  // Button held through reset release: filtered edge arrives in IDLE, ignored
  task automatic test_reset_held_btn();
    int stray;
    stray = 0;
    reset = 1'b1;
    btn   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_tick) stray++;
    end
    btn = 1'b0;
    repeat (HOLD) @(negedge clk);
    checks++;
    if (stray !== 0 || o_cnt !== 4'd0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL held_btn_reset: got ticks=%0d cnt=%0d done=%0b expected 0/0/0", stray, o_cnt, o_done);
    end
    m_cnt   = 0;
    m_state = S_IDLE;
    test_load();
    press_and_check("after_held_btn");
  endtask

  task automatic test_start15();
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    sel     = 1'b1;
    m_start = 15;
    m_cnt   = 0;
    m_state = S_IDLE;
    @(negedge clk);
    test_load();
    tick_total = 0;
    for (int i = 0; i < 15; i++) press_and_check("start15");
    checks++;
    if (tick_total !== 15) begin
      errors++;
      $display("FAIL start15_ticks: got %0d expected 15", tick_total);
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn     = 1'b0;
    load    = 1'b0;
    sel     = 1'b0;
    m_start = 10;
    test_reset();
    test_load();
    test_countdown();
    test_done_ignore();
    test_load_press();
    test_bounce();
    test_async_reset();
    test_reset_held_btn();
    test_start15();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
